panic_desc_collector: RTL and testbench
=======================================

# panic_desc_collector

Sits directly downstream of the header parser. It passes the packet AXI stream through unchanged and latches the parser's descriptor on each packet's first beat. While the packet streams it counts the real byte length. On the last beat it queues a completed descriptor in a small FIFO for the scheduler, tagged with the measured length and a length-mismatch flag.

## Interface
Parameters:
- DATA_WIDTH, 256, AXI stream data width in bits.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- DESC_DEPTH, 8, descriptor FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  reset, asynchronous and active-high.
- s_axis_tdata/tkeep/tvalid/tlast  in  DATA_WIDTH/KEEP_WIDTH/1/1  packet stream, same bus as the parser input.
- s_axis_tready  out  1  equals m_axis_tready && !fifo_full.
- m_axis_tdata/tkeep/tvalid/tlast  out  —  combinational copy of the s_axis fields.
- m_axis_tvalid  out  1  equals s_axis_tvalid && !fifo_full.
- m_axis_tready  in  1  downstream ready.
- s_desc_prio, s_desc_chain, s_desc_time, s_desc_pk_len, s_desc_flow_id  in  `PANIC_DESC_*_SIZE  parser descriptor; valid on the SOP beat.
- m_desc_prio, m_desc_chain, m_desc_time, m_desc_flow_id  out  `PANIC_DESC_*_SIZE  FIFO head.
- m_desc_pk_len  out  `PANIC_DESC_LEN_SIZE  measured byte count.
- m_desc_len_err  out  1  measured length differs from s_desc_pk_len.
- m_desc_valid  out  1 / m_desc_ready  in  1  descriptor handshake.
- stat_pkt_count, stat_err_count  out  32  saturating counters.

## Operation
- A beat is accepted when s_axis_tvalid && s_axis_tready.
- State machine:
  - IDLE: the next accepted beat is SOP.
  - IN_PKT: entered on an accepted SOP without tlast. Returns to IDLE on an accepted tlast beat.
- On accepted SOP:
  - capture prio, chain, time and flow_id into holding registers;
  - capture expected_len = s_desc_pk_len;
  - set byte_cnt = popcount(tkeep).
- On each accepted non-SOP beat: byte_cnt += popcount(tkeep).
  - Saturates at 2^`PANIC_DESC_LEN_SIZE - 1.
- On an accepted tlast beat, push one entry:
  - the captured fields;
  - pk_len = final byte_cnt, including the current beat;
  - len_err = (pk_len != expected_len).
- Single-beat packet (SOP and tlast together): captures and pushes in the same cycle, using the s_desc_* inputs directly.
- Backpressure is conservative: the stream stalls while the FIFO is full, even mid-packet and even when a pop happens in the same cycle.
  - No push is ever lost.
  - No descriptor is ever overwritten.
- FIFO:
  - pop occurs when m_desc_valid && m_desc_ready;
  - simultaneous push and pop when not full leaves occupancy unchanged;
  - read and write pointers wrap modulo DESC_DEPTH;
  - full and empty are distinguished by an extra pointer bit.
- stat_pkt_count increments on every push. stat_err_count increments on every push with len_err set. Both stick at 0xFFFFFFFF.
- tkeep is treated as an arbitrary mask. popcount counts every set bit; contiguity is not required.

## Timing
- Stream path: zero latency, fully combinational.
- Descriptor latency:
  - an entry pushed on cycle N is visible at m_desc_* with m_desc_valid=1 on cycle N+1 when the FIFO was empty;
  - m_desc_* are driven from registered FIFO storage and the read pointer.
- Throughput: one descriptor per cycle in and one per cycle out. Back-to-back single-beat packets sustain full rate while not full.
- Reset (asynchronous, any time, including mid-packet):
  - state = IDLE;
  - FIFO empty, m_desc_valid = 0;
  - byte_cnt, holding registers and stat counters = 0;
  - m_desc_* data outputs = 0.
- After reset deassertion, the first accepted beat is SOP. The partial packet cut by reset is discarded; no descriptor is produced for it.
- m_desc_* fields hold stable while m_desc_valid && !m_desc_ready.

## Test plan
- Single-beat packet: tkeep = 0xFFFFFFFF, tlast = 1, s_desc_pk_len = 32, flow_id = 5.
  - One cycle later m_desc_valid = 1, pk_len = 32, len_err = 0, flow_id = 5.
- 3-beat packet: tkeep = full, full, 0x0000003F, s_desc_pk_len = 70 on SOP, then the inputs change mid-packet.
  - Descriptor carries the SOP-captured fields, pk_len = 70, len_err = 0.
- Mismatch: the same 3-beat packet with s_desc_pk_len = 64.
  - len_err = 1, stat_err_count = 1, stat_pkt_count = 1.
- Full FIFO: 9 single-beat packets with m_desc_ready = 0 and DESC_DEPTH = 8.
  - s_axis_tready drops after 8 pushes; the 9th beat is held.
  - Raising m_desc_ready pops entries in order 1..8; the 9th is then accepted and emitted as entry 9.
- Reset mid-packet: assert rst after beat 2 of 3.
  - Outputs go to 0 immediately and the FIFO is empty.
  - The next packet is parsed as SOP and reports its own length correctly.
- Simultaneous push and pop at occupancy 1: occupancy stays 1, ordering is preserved, and pointer wrap is exercised over 20 packets.

Source files
------------

// File: rtl/panic_desc_collector.sv
// Passes the packet stream through and measures each packet's byte length.
// Completed descriptors, tagged with length and a mismatch flag, queue in a small FIFO.
`ifndef PANIC_DESC_PRIO_SIZE
`define PANIC_DESC_PRIO_SIZE 8
`endif
`ifndef PANIC_DESC_CHAIN_SIZE
`define PANIC_DESC_CHAIN_SIZE 8
`endif
`ifndef PANIC_DESC_TIME_SIZE
`define PANIC_DESC_TIME_SIZE 16
`endif
`ifndef PANIC_DESC_LEN_SIZE
`define PANIC_DESC_LEN_SIZE 16
`endif
`ifndef PANIC_DESC_FLOW_SIZE
`define PANIC_DESC_FLOW_SIZE 16
`endif

module panic_desc_collector #(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DESC_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]             s_axis_tkeep,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]             m_axis_tkeep,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    input  logic [`PANIC_DESC_PRIO_SIZE-1:0]  s_desc_prio,
    input  logic [`PANIC_DESC_CHAIN_SIZE-1:0] s_desc_chain,
    input  logic [`PANIC_DESC_TIME_SIZE-1:0]  s_desc_time,
    input  logic [`PANIC_DESC_LEN_SIZE-1:0]   s_desc_pk_len,
    input  logic [`PANIC_DESC_FLOW_SIZE-1:0]  s_desc_flow_id,
    output logic [`PANIC_DESC_PRIO_SIZE-1:0]  m_desc_prio,
    output logic [`PANIC_DESC_CHAIN_SIZE-1:0] m_desc_chain,
    output logic [`PANIC_DESC_TIME_SIZE-1:0]  m_desc_time,
    output logic [`PANIC_DESC_FLOW_SIZE-1:0]  m_desc_flow_id,
    output logic [`PANIC_DESC_LEN_SIZE-1:0]   m_desc_pk_len,
    output logic                              m_desc_len_err,
    output logic                              m_desc_valid,
    input  logic                              m_desc_ready,
    output logic [31:0]                       stat_pkt_count,
    output logic [31:0]                       stat_err_count
);

    localparam int PW   = `PANIC_DESC_PRIO_SIZE;
    localparam int CW   = `PANIC_DESC_CHAIN_SIZE;
    localparam int TW   = `PANIC_DESC_TIME_SIZE;
    localparam int LW   = `PANIC_DESC_LEN_SIZE;
    localparam int FW   = `PANIC_DESC_FLOW_SIZE;
    localparam int AW   = $clog2(DESC_DEPTH);
    localparam int EW   = PW + CW + TW + FW + LW + 1;
    localparam int CNTW = $clog2(KEEP_WIDTH + 1);

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t          state_q;
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic [EW-1:0]   mem_q [DESC_DEPTH];
    logic [PW-1:0]   prio_q;
    logic [CW-1:0]   chain_q;
    logic [TW-1:0]   time_q;
    logic [FW-1:0]   flow_q;
    logic [LW-1:0]   exp_len_q;
    logic [LW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [31:0]     stat_pkt_q, stat_err_q;

    logic            fifo_full, fifo_empty;
    logic            accept, sop, push, pop;
    logic [CNTW-1:0] beat_bytes;
    logic [LW:0]     sum;
    logic [LW-1:0]   base_cnt, cmp_len;
    logic            push_err;
    logic [EW-1:0]   push_entry;

    function automatic logic [CNTW-1:0] popcnt(input logic [KEEP_WIDTH-1:0] k);
        logic [CNTW-1:0] c;
        c = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) c = c + CNTW'(k[i]);
        return c;
    endfunction

    // Extra pointer bit tells full (MSBs differ) from empty (pointers equal)
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);

    assign s_axis_tready = m_axis_tready && !fifo_full;
    assign m_axis_tvalid = s_axis_tvalid && !fifo_full;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;

    assign accept = s_axis_tvalid && s_axis_tready;
    assign sop    = (state_q == IDLE);
    assign push   = accept && s_axis_tlast;
    assign pop    = m_desc_valid && m_desc_ready;

    assign beat_bytes = popcnt(s_axis_tkeep);
    assign base_cnt   = sop ? '0 : byte_cnt_q;
    assign sum        = {1'b0, base_cnt} + (LW+1)'(beat_bytes);
    assign byte_cnt_d = sum[LW] ? '1 : sum[LW-1:0];

    // A single-beat packet bypasses the holding registers
    assign cmp_len    = sop ? s_desc_pk_len : exp_len_q;
    assign push_err   = (byte_cnt_d != cmp_len);
    assign push_entry = sop ?
        {s_desc_prio, s_desc_chain, s_desc_time, s_desc_flow_id, byte_cnt_d, push_err} :
        {prio_q, chain_q, time_q, flow_q, byte_cnt_d, push_err};

    assign {m_desc_prio, m_desc_chain, m_desc_time,
            m_desc_flow_id, m_desc_pk_len, m_desc_len_err} = mem_q[rd_ptr_q[AW-1:0]];
    assign m_desc_valid   = !fifo_empty;
    assign stat_pkt_count = stat_pkt_q;
    assign stat_err_count = stat_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (accept) begin
            state_q <= s_axis_tlast ? IDLE : IN_PKT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q     <= '0;
            chain_q    <= '0;
            time_q     <= '0;
            flow_q     <= '0;
            exp_len_q  <= '0;
            byte_cnt_q <= '0;
        end else if (accept) begin
            byte_cnt_q <= byte_cnt_d;
            if (sop) begin
                prio_q    <= s_desc_prio;
                chain_q   <= s_desc_chain;
                time_q    <= s_desc_time;
                flow_q    <= s_desc_flow_id;
                exp_len_q <= s_desc_pk_len;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DESC_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pkt_q <= '0;
            stat_err_q <= '0;
        end else if (push) begin
            if (stat_pkt_q != '1) stat_pkt_q <= stat_pkt_q + 32'd1;
            if (push_err && stat_err_q != '1) stat_err_q <= stat_err_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_panic_desc_collector.sv
// Directed bench for panic_desc_collector: vector table plus
// hand-written multi-cycle sequences (full FIFO, reset mid-packet, wrap).
`ifndef PANIC_DESC_PRIO_SIZE
`define PANIC_DESC_PRIO_SIZE 8
`endif
`ifndef PANIC_DESC_CHAIN_SIZE
`define PANIC_DESC_CHAIN_SIZE 8
`endif
`ifndef PANIC_DESC_TIME_SIZE
`define PANIC_DESC_TIME_SIZE 16
`endif
`ifndef PANIC_DESC_LEN_SIZE
`define PANIC_DESC_LEN_SIZE 16
`endif
`ifndef PANIC_DESC_FLOW_SIZE
`define PANIC_DESC_FLOW_SIZE 16
`endif

module tb_panic_desc_collector;

    localparam int DW = 256;
    localparam int KW = 32;
    localparam int DD = 8;
    localparam int PW = `PANIC_DESC_PRIO_SIZE;
    localparam int CW = `PANIC_DESC_CHAIN_SIZE;
    localparam int TW = `PANIC_DESC_TIME_SIZE;
    localparam int LW = `PANIC_DESC_LEN_SIZE;
    localparam int FW = `PANIC_DESC_FLOW_SIZE;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_tdata, m_axis_tdata;
    logic [KW-1:0] s_axis_tkeep, m_axis_tkeep;
    logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [PW-1:0] s_desc_prio, m_desc_prio;
    logic [CW-1:0] s_desc_chain, m_desc_chain;
    logic [TW-1:0] s_desc_time, m_desc_time;
    logic [LW-1:0] s_desc_pk_len, m_desc_pk_len;
    logic [FW-1:0] s_desc_flow_id, m_desc_flow_id;
    logic          m_desc_len_err, m_desc_valid, m_desc_ready;
    logic [31:0]   stat_pkt_count, stat_err_count;

    always #5 clk = ~clk;

    panic_desc_collector #(
        .DATA_WIDTH(DW),
        .KEEP_WIDTH(KW),
        .DESC_DEPTH(DD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .s_desc_prio(s_desc_prio),
        .s_desc_chain(s_desc_chain),
        .s_desc_time(s_desc_time),
        .s_desc_pk_len(s_desc_pk_len),
        .s_desc_flow_id(s_desc_flow_id),
        .m_desc_prio(m_desc_prio),
        .m_desc_chain(m_desc_chain),
        .m_desc_time(m_desc_time),
        .m_desc_flow_id(m_desc_flow_id),
        .m_desc_pk_len(m_desc_pk_len),
        .m_desc_len_err(m_desc_len_err),
        .m_desc_valid(m_desc_valid),
        .m_desc_ready(m_desc_ready),
        .stat_pkt_count(stat_pkt_count),
        .stat_err_count(stat_err_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_beat(input logic [KW-1:0] keep, input logic last,
                            input logic [LW-1:0] plen, input logic [FW-1:0] flow,
                            input logic [PW-1:0] prio);
        s_axis_tdata   = {8{keep}} ^ DW'(flow);
        s_axis_tkeep   = keep;
        s_axis_tlast   = last;
        s_axis_tvalid  = 1'b1;
        s_desc_pk_len  = plen;
        s_desc_flow_id = flow;
        s_desc_prio    = prio;
        s_desc_chain   = CW'(flow + 16'd1);
        s_desc_time    = TW'(flow * 3);
    endtask

    // Called at a negedge; returns at the negedge after the beat was accepted
    task automatic beat(input logic [KW-1:0] keep, input logic last,
                        input logic [LW-1:0] plen, input logic [FW-1:0] flow,
                        input logic [PW-1:0] prio);
        int cyc;
        cyc = 0;
        set_beat(keep, last, plen, flow, prio);
        while (!s_axis_tready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100) chk("tready_timeout", s_axis_tready, 1);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic three_beat(input logic [LW-1:0] plen, input logic exp_err);
        beat(32'hFFFF_FFFF, 1'b0, plen, 16'd11, 8'd3);
        chk("mid_pkt_no_desc", m_desc_valid, 0);
        beat(32'hFFFF_FFFF, 1'b0, 16'd1, 16'd99, 8'd7);
        beat(32'h0000_003F, 1'b1, 16'd2, 16'd98, 8'd6);
        chk("3b_valid", m_desc_valid, 1);
        chk("3b_len", m_desc_pk_len, 70);
        chk("3b_err", m_desc_len_err, exp_err);
        chk("3b_flow", m_desc_flow_id, 11);
        chk("3b_prio", m_desc_prio, 3);
        chk("3b_chain", m_desc_chain, 12);
        chk("3b_time", m_desc_time, 33);
    endtask

    typedef struct {
        logic [KW-1:0] keep;
        logic [LW-1:0] plen;
        logic [FW-1:0] flow;
        logic [PW-1:0] prio;
        logic [LW-1:0] exp_len;
        logic          exp_err;
    } vec_t;

    vec_t vt[6];
    int   exp_pkt, exp_err_cnt;
    logic acc;

    initial begin
        vt[0] = '{32'hFFFF_FFFF, 16'd32, 16'd5,  8'd1, 16'd32, 1'b0};
        vt[1] = '{32'h0000_000F, 16'd4,  16'd6,  8'd2, 16'd4,  1'b0};
        vt[2] = '{32'h8000_0001, 16'd2,  16'd7,  8'd3, 16'd2,  1'b0};
        vt[3] = '{32'h0000_0000, 16'd0,  16'd8,  8'd4, 16'd0,  1'b0};
        vt[4] = '{32'h5555_5555, 16'd15, 16'd9,  8'd5, 16'd16, 1'b1};
        vt[5] = '{32'h0000_FFFF, 16'd16, 16'd10, 8'd6, 16'd16, 1'b0};

        rst = 1'b1;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        s_desc_prio = '0;
        s_desc_chain = '0;
        s_desc_time = '0;
        s_desc_pk_len = '0;
        s_desc_flow_id = '0;
        m_axis_tready = 1'b0;
        m_desc_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_valid", m_desc_valid, 0);
        chk("rst_len", m_desc_pk_len, 0);
        chk("rst_flow", m_desc_flow_id, 0);
        chk("rst_pkt_cnt", stat_pkt_count, 0);
        chk("rst_err_cnt", stat_err_count, 0);

        // Passthrough while downstream stalls: nothing accepted
        set_beat(32'h0000_00FF, 1'b1, 16'd8, 16'h1234, 8'd0);
        #1;
        chk("pt_tvalid", m_axis_tvalid, 1);
        chk("pt_tdata", m_axis_tdata[63:0], {2{32'h0000_00FF}} ^ 64'h1234);
        chk("pt_tkeep", m_axis_tkeep, 32'h0000_00FF);
        chk("pt_tlast", m_axis_tlast, 1);
        chk("pt_tready_low", s_axis_tready, 0);
        @(negedge clk);
        chk("pt_no_push", m_desc_valid, 0);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        #1;
        chk("pt_tvalid_off", m_axis_tvalid, 0);
        @(negedge clk);

        exp_pkt = 0;
        exp_err_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            beat(vt[i].keep, 1'b1, vt[i].plen, vt[i].flow, vt[i].prio);
            exp_pkt++;
            if (vt[i].exp_err) exp_err_cnt++;
            chk($sformatf("vec%0d_valid", i), m_desc_valid, 1);
            chk($sformatf("vec%0d_len", i), m_desc_pk_len, vt[i].exp_len);
            chk($sformatf("vec%0d_err", i), m_desc_len_err, vt[i].exp_err);
            chk($sformatf("vec%0d_flow", i), m_desc_flow_id, vt[i].flow);
            chk($sformatf("vec%0d_prio", i), m_desc_prio, vt[i].prio);
            chk($sformatf("vec%0d_chain", i), m_desc_chain, CW'(vt[i].flow + 16'd1));
            chk($sformatf("vec%0d_time", i), m_desc_time, TW'(vt[i].flow * 3));
        end
        chk("vec_pkt_cnt", stat_pkt_count, exp_pkt);
        chk("vec_err_cnt", stat_err_count, exp_err_cnt);
        @(negedge clk);
        chk("vec_drained", m_desc_valid, 0);

        three_beat(16'd70, 1'b0);
        @(negedge clk);

        do_reset();
        three_beat(16'd64, 1'b1);
        chk("mm_pkt_cnt", stat_pkt_count, 1);
        chk("mm_err_cnt", stat_err_count, 1);
        @(negedge clk);

        // Full FIFO: eight held descriptors, ninth beat stalls
        do_reset();
        m_desc_ready = 1'b0;
        for (int k = 1; k <= 8; k++) beat(32'hFFFF_FFFF, 1'b1, 16'd32, FW'(k), 8'd0);
        chk("full_tready", s_axis_tready, 0);
        chk("full_head", m_desc_flow_id, 1);
        set_beat(32'hFFFF_FFFF, 1'b1, 16'd32, 16'd9, 8'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("full_hold_tready", s_axis_tready, 0);
            chk("full_hold_tvalid", m_axis_tvalid, 0);
            chk("full_hold_head", m_desc_flow_id, 1);
        end
        m_desc_ready = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            chk($sformatf("full_pop%0d_valid", k), m_desc_valid, 1);
            chk($sformatf("full_pop%0d_flow", k), m_desc_flow_id, k);
            acc = s_axis_tvalid && s_axis_tready;
            @(negedge clk);
            if (acc) s_axis_tvalid = 1'b0;
        end
        chk("full_drained", m_desc_valid, 0);
        chk("full_pkt_cnt", stat_pkt_count, 9);

        // Reset mid-packet with a descriptor queued
        do_reset();
        m_desc_ready = 1'b0;
        beat(32'hFFFF_FFFF, 1'b1, 16'd32, 16'd42, 8'd2);
        beat(32'hFFFF_FFFF, 1'b0, 16'd96, 16'd50, 8'd1);
        beat(32'hFFFF_FFFF, 1'b0, 16'd96, 16'd51, 8'd1);
        chk("pre_rst_flow", m_desc_flow_id, 42);
        rst = 1'b1;
        #1;
        chk("arst_valid", m_desc_valid, 0);
        chk("arst_flow", m_desc_flow_id, 0);
        chk("arst_len", m_desc_pk_len, 0);
        chk("arst_prio", m_desc_prio, 0);
        chk("arst_pkt_cnt", stat_pkt_count, 0);
        @(negedge clk);
        rst = 1'b0;
        m_desc_ready = 1'b1;
        beat(32'h0000_00FF, 1'b0, 16'd12, 16'd13, 8'd4);
        beat(32'h0000_000F, 1'b1, 16'd0, 16'd0, 8'd0);
        chk("post_rst_len", m_desc_pk_len, 12);
        chk("post_rst_err", m_desc_len_err, 0);
        chk("post_rst_flow", m_desc_flow_id, 13);
        chk("post_rst_pkt_cnt", stat_pkt_count, 1);
        @(negedge clk);

        // Push and pop together at occupancy one, wrapping the pointers
        beat(32'hFFFF_FFFF, 1'b1, 16'd32, 16'd100, 8'd0);
        for (int i = 1; i <= 20; i++) begin
            chk($sformatf("wrap%0d_valid", i), m_desc_valid, 1);
            chk($sformatf("wrap%0d_flow", i), m_desc_flow_id, 99 + i);
            beat(32'hFFFF_FFFF, 1'b1, 16'd32, FW'(100 + i), 8'd0);
        end
        chk("wrap_last_flow", m_desc_flow_id, 120);
        @(negedge clk);
        chk("wrap_drained", m_desc_valid, 0);
        chk("wrap_pkt_cnt", stat_pkt_count, 22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
